// File: rtl/reg_shift_seq.sv
// Multi-cycle ARM register-amount shifter: produces Val2 and shifter carry-out
// one bit per cycle while the pipeline is held on busy.
module reg_shift_seq #(
    parameter int REGISTER_LEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flush,
    input  logic [REGISTER_LEN-1:0] val_rm,
    input  logic [7:0]              rs_val,
    input  logic [1:0]              shift_type,
    input  logic                    carry_in,
    output logic                    busy,
    output logic                    done,
    output logic [REGISTER_LEN-1:0] val2_out,
    output logic                    carry_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam int MSB = REGISTER_LEN - 1;

    logic [1:0]              state;
    logic [1:0]              op_q;
    logic [5:0]              cnt;
    logic [REGISTER_LEN-1:0] w;
    logic                    c;

    logic [5:0]              load_cnt;
    logic                    load_c;
    logic [REGISTER_LEN-1:0] step_w;
    logic                    step_c;

    // Clamp the amount so that over-range shifts land on ARM results naturally:
    // 33 LSL/LSR steps clear value and carry, 32 ASR steps saturate to sign.
    always_comb begin
        load_cnt = 6'd0;
        load_c   = carry_in;
        case (shift_type)
            OP_LSL, OP_LSR: load_cnt = (rs_val > 8'd33) ? 6'd33 : rs_val[5:0];
            OP_ASR:         load_cnt = (rs_val > 8'd32) ? 6'd32 : rs_val[5:0];
            default: begin
                load_cnt = {1'b0, rs_val[4:0]};
                // Rotate by a non-zero multiple of 32: value unchanged, carry = bit 31.
                if (rs_val != 8'd0 && rs_val[4:0] == 5'd0)
                    load_c = val_rm[MSB];
            end
        endcase
    end

    always_comb begin
        step_w = w;
        step_c = c;
        case (op_q)
            OP_LSL: begin
                step_c = w[MSB];
                step_w = {w[MSB-1:0], 1'b0};
            end
            OP_LSR: begin
                step_c = w[0];
                step_w = {1'b0, w[MSB:1]};
            end
            OP_ASR: begin
                step_c = w[0];
                step_w = {w[MSB], w[MSB:1]};
            end
            default: begin
                step_c = w[0];
                step_w = {w[0], w[MSB:1]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_q  <= OP_LSL;
            cnt   <= 6'd0;
            w     <= '0;
            c     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_q  <= shift_type;
                        cnt   <= load_cnt;
                        w     <= val_rm;
                        c     <= load_c;
                        state <= (load_cnt != 6'd0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        w   <= step_w;
                        c   <= step_c;
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd1)
                            state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign val2_out  = w;
    assign carry_out = c;

endmodule

// File: tb/tb_reg_shift_seq.sv
// Directed bench for reg_shift_seq: result values, done latency, busy window,
// ignored restarts, flush and asynchronous reset.
module tb_reg_shift_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [31:0] val_rm;
    logic [7:0]  rs_val;
    logic [1:0]  shift_type;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [31:0] val2_out;
    logic        carry_out;

    int n_chk;
    int n_pass;

    reg_shift_seq #(.REGISTER_LEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .val_rm    (val_rm),
        .rs_val    (rs_val),
        .shift_type(shift_type),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .val2_out  (val2_out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Issue one request in cycle 0 and watch 40 cycles. ecyc==0 means no done expected.
    task automatic run(input string tag, input logic [31:0] rm, input logic [7:0] rs,
                       input logic [1:0] ty, input logic ci, input int flush_at,
                       input int restart_at, input logic [31:0] ev, input logic ec,
                       input int ecyc);
        int          dcyc;
        int          ndone;
        logic        busy_ok;
        logic [31:0] v;
        logic        cv;
        dcyc = 0; ndone = 0; busy_ok = 1'b1; v = '0; cv = 1'b0;
        @(negedge clk);
        val_rm = rm; rs_val = rs; shift_type = ty; carry_in = ci; start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            if (done) begin
                ndone++;
                if (dcyc == 0) begin
                    dcyc = cyc; v = val2_out; cv = carry_out;
                end
            end
            if (ecyc != 0 && cyc <= ecyc && !busy) busy_ok = 1'b0;
            if (ecyc != 0 && cyc == ecyc + 1) chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
            if (flush_at != 0 && cyc == flush_at + 1) chk({tag, "_flush_busy"}, {31'd0, busy}, 32'd0);
            if (cyc == flush_at) flush = 1'b1;
            if (cyc == restart_at) begin
                start = 1'b1; val_rm = ~rm; rs_val = 8'd1;
            end
        end
        chk({tag, "_done_cyc"}, dcyc, ecyc);
        chk({tag, "_done_cnt"}, ndone, (ecyc != 0) ? 1 : 0);
        if (ecyc != 0) begin
            chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
            chk({tag, "_val"}, v, ev);
            chk({tag, "_carry"}, {31'd0, cv}, {31'd0, ec});
        end
    endtask

    initial begin
        int nd;
        int nb;
        n_chk = 0; n_pass = 0;
        rst = 1'b0; start = 1'b0; flush = 1'b0;
        val_rm = '0; rs_val = '0; shift_type = '0; carry_in = 1'b0;
        #12;
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_done",  {31'd0, done},      32'd0);
        chk("rst_val",   val2_out,           32'd0);
        chk("rst_carry", {31'd0, carry_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run("lsl4",   32'h0000_000F, 8'd4,   2'b00, 1'b0, 0, 0, 32'h0000_00F0, 1'b0, 5);
        run("lsr33",  32'h8000_0001, 8'd33,  2'b01, 1'b0, 0, 0, 32'h0000_0000, 1'b0, 34);
        run("lsr32",  32'h8000_0001, 8'd32,  2'b01, 1'b0, 0, 0, 32'h0000_0000, 1'b1, 33);
        run("lsl32",  32'h0000_0003, 8'd32,  2'b00, 1'b0, 0, 0, 32'h0000_0000, 1'b1, 33);
        run("asr200", 32'h8000_0000, 8'd200, 2'b10, 1'b0, 0, 0, 32'hFFFF_FFFF, 1'b1, 33);
        run("asr4",   32'h8000_0010, 8'd4,   2'b10, 1'b1, 0, 0, 32'hF800_0001, 1'b0, 5);
        run("ror8",   32'h0000_00AB, 8'd8,   2'b11, 1'b0, 0, 0, 32'hAB00_0000, 1'b1, 9);
        run("ror40",  32'h0000_0012, 8'd40,  2'b11, 1'b1, 0, 0, 32'h1200_0000, 1'b0, 9);
        run("ror32",  32'h8000_0001, 8'd32,  2'b11, 1'b0, 0, 0, 32'h8000_0001, 1'b1, 1);
        run("zero_lsr", 32'h1234_5678, 8'd0, 2'b01, 1'b1, 0, 0, 32'h1234_5678, 1'b1, 1);
        run("zero_ror", 32'hCAFE_0000, 8'd0, 2'b11, 1'b1, 0, 0, 32'hCAFE_0000, 1'b1, 1);
        run("restart",  32'h0000_0001, 8'd10, 2'b00, 1'b0, 0, 3, 32'h0000_0400, 1'b0, 11);
        run("flush",    32'h0000_0001, 8'd10, 2'b00, 1'b0, 3, 0, 32'h0, 1'b0, 0);

        // flush and start together in IDLE: request dropped
        @(negedge clk);
        val_rm = 32'h5; rs_val = 8'd2; shift_type = 2'b00; start = 1'b1; flush = 1'b1;
        nd = 0; nb = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0; flush = 1'b0;
            if (done) nd++;
            if (busy) nb++;
        end
        chk("fl_start_busy", nb, 0);
        chk("fl_start_done", nd, 0);

        // asynchronous reset between edges mid-SHIFT
        @(negedge clk);
        val_rm = 32'h0000_000F; rs_val = 8'd10; shift_type = 2'b00; carry_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy",  {31'd0, busy},      32'd0);
        chk("arst_done",  {31'd0, done},      32'd0);
        chk("arst_val",   val2_out,           32'd0);
        chk("arst_carry", {31'd0, carry_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run("post_rst", 32'h0000_000F, 8'd4, 2'b00, 1'b0, 0, 0, 32'h0000_00F0, 1'b0, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_shift_seq.md
Name: reg_shift_seq

Overview:
- Multi-cycle sequencer for register-specified shifter operands: shift amount comes from Rs[7:0], i.e. shift_operand[4]==1 with immediate==0.
- Sits beside the single-cycle immediate/constant-shift operand generator in the execute stage. Produces Val2 and shifter carry-out over several cycles.
- The hazard/stall logic holds the pipeline while busy is high.
- Shifts one bit per cycle and clamps the iteration count, so amounts 0..255 follow ARM semantics.

Parameters:
- REGISTER_LEN, 32, datapath width in bits; the count logic is sized for 32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE.
- flush  input  1  synchronous abort from the pipeline flush.
- val_rm  input  REGISTER_LEN  operand Rm.
- rs_val  input  8  shift amount, Rs[7:0].
- shift_type  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- carry_in  input  1  current CPSR C flag.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse; result valid.
- val2_out  output  REGISTER_LEN  shifted operand.
- carry_out  output  1  shifter carry-out.

Behaviour:
- Reset (rst low, asynchronous):
  - state returns to IDLE.
  - busy=0, done=0, val2_out=0, carry_out=0, internal count=0.
  - Takes effect immediately, including mid-operation. No done is produced for the aborted request.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1, flush=0 at a rising edge:
  - Latch val_rm into the working register and carry_in into the carry register.
  - Load count N.
  - Go to SHIFT if N>0, else go to DONE.
- Iteration count N (6 bits):
  - LSL/LSR: N=min(rs_val,33).
  - ASR: N=min(rs_val,32).
  - ROR: N=rs_val[4:0].
- ROR special case: if rs_val!=0 and rs_val[4:0]==0, then N=0, but the latched carry is set to val_rm[REGISTER_LEN-1].
- Zero amount: rs_val==0 for any type gives the value unchanged and carry=carry_in.
- SHIFT, one bit per cycle:
  - LSL: carry<=w[MSB]; w<={w[MSB-1:0],0}.
  - LSR: carry<=w[0]; w<={0,w[MSB:1]}.
  - ASR: carry<=w[0]; w<={w[MSB],w[MSB:1]}.
  - ROR: carry<=w[0]; w<={w[0],w[MSB:1]}.
  - count decrements each cycle. On the edge that performs the last shift (count==1), go to DONE.
- Resulting edge cases (no extra logic needed):
  - LSL 32 gives 0 with carry=Rm[0].
  - LSL/LSR >=33 gives 0 with carry 0.
  - ASR >=32 gives all sign bits with carry=sign.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - val2_out/carry_out show the working registers continuously. They hold the last result until the next accepted start.
- Latency: with start sampled during cycle 0, done is high in cycle N+1. Worst case is cycle 34.
- start while busy (SHIFT or DONE) is ignored and not queued. The requester must see busy=0 before asserting start.
- flush=1 in SHIFT or DONE: go to IDLE at the next edge with no done pulse. val2_out/carry_out keep their partial values (don't-care).
- flush and start together in IDLE: flush wins and the request is dropped.
- done and busy are both high in DONE. busy falls in the cycle after done.

Test Plan:
- LSL: val_rm=0x0000000F, rs_val=4, carry_in=0 -> done in cycle 5; val2_out=0x000000F0, carry_out=0; busy high cycles 1-5.
- LSR: val_rm=0x80000001, rs_val=33 -> done in cycle 34; val2_out=0, carry_out=0. Repeat with rs_val=32 -> val2_out=0, carry_out=1, done in cycle 33.
- ASR: val_rm=0x80000000, rs_val=200 -> N=32, done in cycle 33; val2_out=0xFFFFFFFF, carry_out=1.
- ROR:
  - val_rm=0x000000AB, rs_val=8 -> val2_out=0xAB000000, carry_out=1, done in cycle 9.
  - rs_val=32, val_rm=0x80000001 -> val2_out unchanged, carry_out=1, done in cycle 1.
  - rs_val=0, carry_in=1, any type -> val2_out=val_rm, carry_out=1, done in cycle 1.
- Control:
  - A start pulsed during SHIFT is ignored; exactly one done pulse.
  - flush in cycle 3 of an LSL-by-10 -> busy=0 in cycle 4, no done.
  - flush and start in the same IDLE cycle -> stays IDLE.
- Reset: assert rst low mid-SHIFT, asynchronously between edges -> busy, done, val2_out, carry_out go to 0 immediately. After release, a new start completes normally.
